// File: rtl/vga_scan_controller.sv
// vga_scan_controller
//   Raster scan generator for a 640x480 VGA timing. Produces the DrawX/DrawY
//   position that feeds the colour mapper. It samples the mapper's RGB for that
//   position and drives registered, blank-gated colour together with HS/VS/blank.
//   It also emits a per-frame start pulse and a free-running frame counter.
//   Pixel rate is half of Clk. An internal phase bit gates every update.
// Ports
//   Clk, Reset            system clock, synchronous active-high reset
//   Red_in/Green_in/Blue_in  mapper colour for the current DrawX/DrawY
//   DrawX, DrawY          current horizontal / vertical counters
//   pixel_clk             pixel enable, high on every second Clk
//   hs, vs                active-low syncs (registered)
//   blank                 1 = visible pixel on the pins (registered)
//   VGA_R/VGA_G/VGA_B     registered, blank-gated colour
//   frame_start           one-Clk pulse after the last pixel of a frame
//   frame_cnt             frames completed since reset (wraps)
module vga_scan_controller #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  Red_in,
  input  logic [7:0]  Green_in,
  input  logic [7:0]  Blue_in,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        pixel_clk,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic        phase_q;
  logic [9:0]  hc_q, hc_d;
  logic [9:0]  vc_q, vc_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        blank_q, blank_d;
  logic [23:0] rgb_q, rgb_d;
  logic        fs_q, fs_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic visible, hs_raw, vs_raw, eof;

  // Timing decode from the current position; registered below so the pins
  // lag DrawX/DrawY by exactly one pixel period, sync and colour together.
  always_comb begin
    visible = (hc_q < H_VIS) && (vc_q < V_VIS);
    hs_raw  = !((hc_q >= HS_START) && (hc_q < HS_END));
    vs_raw  = !((vc_q >= VS_START) && (vc_q < VS_END));
    eof     = (hc_q == H_LAST) && (vc_q == V_LAST);
  end

  always_comb begin
    hc_d        = hc_q;
    vc_d        = vc_q;
    hs_d        = hs_q;
    vs_d        = vs_q;
    blank_d     = blank_q;
    rgb_d       = rgb_q;
    fs_d        = 1'b0;   // pulse lasts a single Clk, even off pixel edges
    frame_cnt_d = frame_cnt_q;
    if (phase_q) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
      end else begin
        hc_d = hc_q + 10'd1;
      end
      hs_d    = hs_raw;
      vs_d    = vs_raw;
      blank_d = visible;
      rgb_d   = visible ? {Red_in, Green_in, Blue_in} : 24'd0;
      if (eof) begin
        fs_d        = 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      phase_q     <= 1'b0;
      hc_q        <= '0;
      vc_q        <= '0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      blank_q     <= 1'b0;
      rgb_q       <= '0;
      fs_q        <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      phase_q     <= ~phase_q;
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      blank_q     <= blank_d;
      rgb_q       <= rgb_d;
      fs_q        <= fs_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign pixel_clk   = phase_q;
  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign frame_start = fs_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
